// File: rtl/ahb_display_mux.sv
// ahb_display_mux: AHB-Lite slave scanning a multiplexed 7-segment display
// with per-digit enable, hex/raw select, PWM brightness and byte-lane writes.
module ahb_display_mux #(
    parameter int N_DIGITS = 8,
    parameter int D_WIDTH  = 18
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    output logic [N_DIGITS-1:0] digit,
    output logic [7:0]          segment
);
    localparam int IW = $clog2(N_DIGITS);

    logic                dp_valid;
    logic                dp_write;
    logic [5:0]          dp_addr;
    logic [2:0]          dp_size;

    logic [7:0]          raw [N_DIGITS];
    logic [3:0]          val [N_DIGITS];
    logic [N_DIGITS-1:0] en_mask;
    logic [N_DIGITS-1:0] hex_mask;
    logic [N_DIGITS-1:0] dp_mask;
    logic [3:0]          br;

    logic [D_WIDTH-1:0]  pre;
    logic [IW-1:0]       idx;

    logic [3:0]          be;
    logic                wr_en;
    logic                addr_ok;
    int                  widx;
    logic [31:0]         rdata;
    logic [3:0]          tslot;
    logic                active;
    logic                lit;
    logic [7:0]          pat;
    logic [N_DIGITS-1:0] onehot;
    logic                unused;

    function automatic logic [6:0] hexdec(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign HREADYOUT = 1'b1;
    assign unused    = ^{HADDR[31:6], HTRANS[0]};
    assign addr_ok   = HSEL & HREADY & HTRANS[1];
    assign wr_en     = dp_valid & dp_write;
    assign widx      = int'(dp_addr[5:2]);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= '0;
        end else begin
            dp_valid <= addr_ok;
            if (addr_ok) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR[5:0];
                dp_size  <= HSIZE;
            end
        end
    end

    // Little-endian lane enables for the transfer now in its data phase
    always_comb begin
        be = 4'b0000;
        case (dp_size)
            3'b000:  be = 4'b0001 << dp_addr[1:0];
            3'b001:  be = dp_addr[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int d = 0; d < N_DIGITS; d++) begin
                raw[d] <= '0;
                val[d] <= '0;
            end
            en_mask  <= '0;
            hex_mask <= '0;
            dp_mask  <= '0;
            br       <= '0;
        end else if (wr_en) begin
            for (int d = 0; d < N_DIGITS; d++) begin
                if (widx == d / 4 && be[d % 4])
                    raw[d] <= HWDATA[8*(d%4) +: 8];
                if (widx == 4 + d / 8 && be[(d % 8) / 2])
                    val[d] <= HWDATA[4*(d%8) +: 4];
                if (widx == 6 && be[d / 8])
                    en_mask[d] <= HWDATA[d];
                if (widx == 6 && be[2 + d / 8])
                    hex_mask[d] <= HWDATA[16 + d];
                if (widx == 7 && be[d / 8])
                    dp_mask[d] <= HWDATA[d];
            end
            if (widx == 7 && be[2])
                br <= HWDATA[19:16];
        end
    end

    always_comb begin
        rdata = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (widx == d / 4)
                rdata[8*(d%4) +: 8] = raw[d];
            if (widx == 4 + d / 8)
                rdata[4*(d%8) +: 4] = val[d];
            if (widx == 6) begin
                rdata[d]      = en_mask[d];
                rdata[16 + d] = hex_mask[d];
            end
            if (widx == 7)
                rdata[d] = dp_mask[d];
        end
        if (widx == 7) begin
            rdata[19:16] = br;
            rdata[28:24] = 5'(idx);
        end
    end

    assign HRDATA = (dp_valid & ~dp_write) ? rdata : '0;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= pre + 1'b1;
            if (&pre)
                idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Top four prescaler bits form the PWM phase within a slot
    assign tslot  = pre[D_WIDTH-1 -: 4];
    assign active = (br == 4'hF) | (tslot < br);
    assign lit    = en_mask[idx] & active;
    assign onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;
    assign pat    = hex_mask[idx] ? {dp_mask[idx], hexdec(val[idx])}
                                  : raw[idx];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            digit   <= '1;
            segment <= 8'hFF;
        end else begin
            digit   <= lit ? ~onehot : '1;
            segment <= lit ? ~pat : 8'hFF;
        end
    end

endmodule

// File: tb/tb_ahb_display_mux.sv
// tb_ahb_display_mux: random and directed bus traffic against a word-level
// model of the display registers and the slot/PWM scan timing.
module tb_ahb_display_mux;
    localparam int N    = 8;
    localparam int DW   = 5;
    localparam int SLOT = 32;

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [7:0]  digit;
    logic [7:0]  segment;

    always #5 clk = ~clk;

    ahb_display_mux #(.N_DIGITS(N), .D_WIDTH(DW)) dut (
        .HCLK(clk), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .digit(digit), .segment(segment)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %08h want %08h", name, got, want);
    endtask

    // Model: readable image of the eight register words, plus a cycle
    // count since reset from which slot index and PWM phase follow.
    logic [31:0] m_reg [8];
    int          n = 0;
    bit          chk_on = 1'b0;
    logic [7:0]  exp_d;
    logic [7:0]  exp_s;
    bit          wr_pend = 1'b0;
    logic [5:0]  wr_addr;
    logic [2:0]  wr_size;
    logic [31:0] wr_data;

    function automatic logic [6:0] hexdec(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    function automatic logic [31:0] wmask(input int w);
        case (w)
            0, 1, 4: return 32'hFFFF_FFFF;
            6:       return 32'h00FF_00FF;
            7:       return 32'h000F_00FF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [2:0] sz,
                                          input logic [1:0] a);
        case (sz)
            3'd0:    return 32'hFF << (8 * a);
            3'd1:    return a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            3'd2:    return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input int w);
        logic [31:0] r;
        if (w > 7) return 32'h0;
        r = m_reg[w];
        if (w == 7) r = r | 32'(((n / SLOT) % N) << 24);
        return r;
    endfunction

    function automatic logic [15:0] model_out(input int c);
        int         i;
        int         p;
        logic [3:0] b;
        bit         on;
        logic [7:0] s;
        i  = (c / SLOT) % N;
        p  = c % SLOT;
        b  = m_reg[7][19:16];
        on = m_reg[6][i] && (b == 4'hF || (p / (SLOT / 16)) < b);
        if (m_reg[6][16 + i]) s = {m_reg[7][i], hexdec(m_reg[4][4*i +: 4])};
        else s = m_reg[i / 4][8*(i % 4) +: 8];
        if (!on) return 16'hFFFF;
        return {~(8'd1 << i), ~s};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] mk,
                                          input logic [31:0] d);
        return (old & ~mk) | (d & mk);
    endfunction

    always @(posedge clk) begin
        if (!HRESETn) begin
            for (int w = 0; w < 8; w++) m_reg[w] <= '0;
            n      <= 0;
            exp_d  <= 8'hFF;
            exp_s  <= 8'hFF;
            chk_on <= 1'b1;
        end else begin
            {exp_d, exp_s} <= model_out(n);
            n <= n + 1;
            if (wr_pend && !wr_addr[5])
                m_reg[wr_addr[4:2]] <= merge(m_reg[wr_addr[4:2]],
                    wmask(int'(wr_addr[4:2])) & lanes(wr_size, wr_addr[1:0]),
                    wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("digit", 32'(digit), 32'(exp_d));
            chk("segment", 32'(segment), 32'(exp_s));
            chk("hreadyout", 32'(HREADYOUT), 32'h1);
        end
    end

    // Bus tasks start and end just after a rising edge
    task automatic xfer(input bit wr, input logic [5:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = {26'($urandom()), a};
        HSIZE  = sz;
        @(posedge clk); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        if (wr) begin
            HWDATA  = wd;
            wr_addr = a;
            wr_size = sz;
            wr_data = wd;
            wr_pend = 1'b1;
        end
        @(negedge clk);
        rd = HRDATA;
        if (!wr) chk($sformatf("read %02h", a), HRDATA, m_read(int'(a[5:2])));
        @(posedge clk); #1;
        wr_pend = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(1'b1, a, 3'd2, d, dummy);
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        xfer(1'b0, a, 3'd2, 32'h0, d);
    endtask

    task automatic wr_rd(input logic [5:0] a, input logic [31:0] wd,
                         output logic [31:0] r);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = {26'h0, a};
        HSIZE  = 3'd2;
        @(posedge clk); #1;
        HWDATA  = wd;
        wr_addr = a;
        wr_size = 3'd2;
        wr_data = wd;
        wr_pend = 1'b1;
        HWRITE  = 1'b0;
        @(posedge clk); #1;
        wr_pend = 1'b0;
        HSEL    = 1'b0;
        HTRANS  = 2'b00;
        @(negedge clk);
        r = HRDATA;
        chk("b2b read", r, m_read(int'(a[5:2])));
        @(posedge clk); #1;
    endtask

    // Bus activity that must not be taken as a transfer to this slave
    task automatic junk();
        HWRITE = 1'b1;
        HSIZE  = 3'd2;
        HADDR  = $urandom();
        case ($urandom_range(0, 2))
            0: begin HSEL = 1'b0; HTRANS = 2'b10; end
            1: begin HSEL = 1'b1; HTRANS = 2'($urandom_range(0, 1)); end
            default: begin HSEL = 1'b1; HTRANS = 2'b11; HREADY = 1'b0; end
        endcase
        @(posedge clk); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HREADY = 1'b1;
        HWDATA = $urandom();
        @(posedge clk); #1;
    endtask

    // Stop at the negedge where the outputs show slot s, phase p
    task automatic at_out(input int s, input int p, input string name);
        int k;
        k = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            k++;
        end while (!(((n - 1) / SLOT) % N == s && (n - 1) % SLOT == p)
                   && k < 1000);
        if (k >= 1000) chk({name, " timeout"}, 32'h0, 32'h1);
    endtask

    logic [31:0] r;
    logic [5:0]  ra;
    logic [2:0]  rs;
    int          cnt;
    int          cnt8;
    int          cnt0;

    initial begin
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HREADY  = 1'b1;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'd0;
        HWDATA  = '0;
        repeat (2) @(posedge clk);
        #1 HRESETn = 1'b1;
        @(negedge clk);
        chk("reset digit", 32'(digit), 32'hFF);
        chk("reset segment", 32'(segment), 32'hFF);
        @(posedge clk); #1;
        for (int w = 0; w < 8; w++) begin
            rd(6'(w * 4), r);
            chk($sformatf("reset word %0d", w), r, 32'h0);
        end

        wr(6'h00, 32'h0804_0201);
        wr(6'h04, 32'h8040_2010);
        wr(6'h18, 32'h0000_00FF);
        wr(6'h1C, 32'h000F_0000);
        at_out(0, 5, "slot0");
        chk("raw slot0 digit", 32'(digit), 32'hFE);
        chk("raw slot0 segment", 32'(segment), 32'hFE);
        at_out(1, 5, "slot1");
        chk("raw slot1 digit", 32'(digit), 32'hFD);
        chk("raw slot1 segment", 32'(segment), 32'hFD);
        at_out(3, 2, "slot3");
        @(posedge clk); #1;
        rd(6'h1C, r);
        chk("scan index", 32'(r[28:24]), 32'd3);

        wr(6'h10, 32'h7654_3210);
        xfer(1'b1, 6'h1A, 3'd0, 32'h00FF_0000, r);
        rd(6'h18, r);
        chk("ctrl byte write", r, 32'h00FF_00FF);
        at_out(0, 5, "hex0");
        chk("hex slot0 segment", 32'(segment), 32'hC0);
        at_out(7, 5, "hex7");
        chk("hex slot7 segment", 32'(segment), 32'hF8);
        @(posedge clk); #1;
        xfer(1'b1, 6'h1C, 3'd0, 32'h0000_0001, r);
        at_out(0, 5, "dp0");
        chk("dp slot0 segment", 32'(segment), 32'h40);
        @(posedge clk); #1;

        wr(6'h1C, 32'h0004_0001);
        at_out(2, 0, "pwm");
        cnt  = 0;
        cnt8 = 0;
        for (int c = 0; c < SLOT; c++) begin
            if (c > 0) @(negedge clk);
            if (digit == 8'hFB) begin
                cnt++;
                if (c < 8) cnt8++;
            end
        end
        chk("br4 low cycles", 32'(cnt), 32'd8);
        chk("br4 low window", 32'(cnt8), 32'd8);
        @(posedge clk); #1;
        wr(6'h1C, 32'h0000_0001);
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (digit != 8'hFF) cnt++;
        end
        chk("br0 dark", 32'(cnt), 32'd0);
        @(posedge clk); #1;

        wr(6'h1C, 32'h000F_0001);
        wr(6'h18, 32'h00FF_000F);
        repeat (2) @(negedge clk);
        cnt  = 0;
        cnt0 = 0;
        repeat (300) begin
            @(negedge clk);
            if (digit[7:4] != 4'hF) cnt++;
            if (digit == 8'hFE) cnt0++;
        end
        chk("enable mask high digits", 32'(cnt), 32'd0);
        chk("enable mask digit0 lit", 32'(cnt0 > 0), 32'd1);
        at_out(6, 3, "idx6");
        @(posedge clk); #1;
        rd(6'h1C, r);
        chk("index with masked digits", 32'(r[28:24]), 32'd6);

        wr_rd(6'h18, 32'h00AA_0055, r);
        chk("b2b ctrl", r, 32'h00AA_0055);
        wr_rd(6'h14, 32'hDEAD_BEEF, r);
        chk("val1 absent", r, 32'h0);

        repeat (200) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    rs = 3'($urandom_range(0, 2));
                    ra = 6'($urandom_range(0, 63));
                    if (rs == 3'd1) ra[0] = 1'b0;
                    if (rs == 3'd2) ra[1:0] = 2'b00;
                    xfer(1'b1, ra, rs, $urandom(), r);
                end
                3: begin
                    ra = 6'($urandom_range(0, 15) * 4);
                    rd(ra, r);
                end
                4: junk();
                default: begin
                    repeat ($urandom_range(1, 40)) @(posedge clk);
                    #1;
                end
            endcase
        end

        wr(6'h18, 32'h00FF_00FF);
        wr(6'h1C, 32'h000F_0000);
        at_out(5, 10, "slot5");
        chk("slot5 lit", 32'(digit), 32'hDF);
        @(posedge clk); #1;
        HRESETn = 1'b0;
        @(posedge clk); #1;
        HRESETn = 1'b1;
        @(negedge clk);
        chk("midscan reset digit", 32'(digit), 32'hFF);
        chk("midscan reset segment", 32'(segment), 32'hFF);
        @(posedge clk); #1;
        rd(6'h18, r);
        chk("midscan reset ctrl", r, 32'h0);
        rd(6'h1C, r);
        chk("midscan reset disp", r, 32'h0);
        rd(6'h00, r);
        chk("midscan reset raw0", r, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
